spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) master transaction controller.
- Sequences chip select, serial clock, bit shifting and multi-byte bursts.
- User side has a byte-wide valid/ready handshake; pin side connects directly to one SPI slave.
- Sits between system logic and the SPI pins and owns all SPI timing.

Parameters:
CLKS_PER_HALF_BIT, 2, i_Clk cycles per SCLK half period (H); legal >= 2
CS_IDLE_CLKS, 2, minimum cycles o_SPI_CS_n stays high between transactions; legal >= 1

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  asynchronous reset, active-high
i_TX_Count  in  8  bytes in the transaction; sampled only on the first byte; 0 treated as 1
i_TX_Byte  in  8  byte to transmit, MSB first
i_TX_DV  in  1  byte valid; accepted only when o_TX_Ready=1
o_TX_Ready  out  1  controller can accept a byte
o_RX_Byte  out  8  last received byte
o_RX_DV  out  1  one-cycle pulse; o_RX_Byte is valid
o_Busy  out  1  high from first-byte accept until CS_IDLE exits
o_SPI_Clk  out  1  SCLK; idles low
i_SPI_MISO  in  1  serial data from slave
o_SPI_MOSI  out  1  serial data to slave
o_SPI_CS_n  out  1  chip select, active-low

Behaviour:
- Reset is asynchronous and active-high: i_Rst high forces all outputs to reset values immediately, on the same edge, and holds them there. Any transaction in flight is abandoned.
  - o_TX_Ready=0, o_RX_Byte=0, o_RX_DV=0, o_Busy=0, o_SPI_Clk=0, o_SPI_MOSI=0, o_SPI_CS_n=1.
  - FSM goes to IDLE.
  - After reset deasserts, the first cycle is IDLE with o_TX_Ready=1.
- FSM states: IDLE, XFER, WAIT_BYTE, CS_HOLD, CS_IDLE.
- IDLE:
  - o_TX_Ready=1.
  - i_TX_DV=1 at an edge latches i_TX_Byte into the shift register and i_TX_Count into the remaining counter (0 becomes 1).
  - Same edge: o_SPI_CS_n<=0, o_SPI_MOSI<=bit7, o_TX_Ready<=0, o_Busy<=1, go to XFER.
- XFER:
  - Let t=0 be the edge where CS_n falls or the byte is accepted.
  - SCLK rises at t=(2k+1)H and falls at t=(2k+2)H, for k=0..7.
  - MISO is sampled into the LSB of the RX shift register on each rising edge.
  - MOSI shifts to the next bit on each falling edge, except the 8th.
  - At t=16H: o_RX_Byte<=shifted value and o_RX_DV<=1 for exactly one cycle. Remaining count is decremented.
  - Then go to WAIT_BYTE if remaining>0, else CS_HOLD.
- WAIT_BYTE:
  - CS_n stays low, SCLK stays low, o_TX_Ready=1.
  - Waits indefinitely for i_TX_DV.
  - Accept loads the byte, drives MOSI=bit7, and returns to XFER with a new t=0.
  - i_TX_Count is ignored here.
- CS_HOLD: H cycles with CS_n low, then CS_n<=1 and go to CS_IDLE.
- CS_IDLE:
  - CS_IDLE_CLKS cycles with o_TX_Ready=0, then go to IDLE.
  - o_Busy drops on the edge that enters IDLE.
- i_TX_DV while o_TX_Ready=0 is ignored. It is not queued.
- i_TX_DV held high continuously: bytes are accepted back-to-back. Each byte is accepted on the first cycle o_TX_Ready is high.
- Byte period is 16H cycles from accept to o_RX_DV. Minimum gap between bytes in a burst is 1 cycle in WAIT_BYTE.
- SCLK never glitches: at most one transition per H cycles. SCLK is registered.
- Half-bit counter width is clog2(CLKS_PER_HALF_BIT). Bit counter is 3 bits and wraps 7->0 at byte end.

Decomposition:
- Shared package spi_pkg holds:
  - FSM state localparams (3-bit encoding: IDLE=0, XFER=1, WAIT_BYTE=2, CS_HOLD=3, CS_IDLE=4).
  - SPI mode constants (CPOL=0, CPHA=0).
  - Default CLKS_PER_HALF_BIT.
- One sub-module: spi_clk_gen.
  - Contains the half-bit counter.
  - Produces o_Rise_Strobe, o_Fall_Strobe and the registered SCLK level, enabled only in XFER.
  - Counter and phase are cleared on enable low.

Test Plan:
- Reset mid-XFER (assert at t=5, H=2): CS_n=1, SCLK=0, MOSI=0, o_RX_DV=0 the same cycle. o_TX_Ready=1 the first cycle after release. No o_RX_DV ever emitted for the aborted byte.
- Single byte, H=2, MISO looped to MOSI, i_TX_Byte=0xA5, Count=1:
  - CS_n low for 34 cycles; exactly 8 SCLK rises at t=2,6,...,30.
  - o_RX_DV at t=32 with o_RX_Byte=0xA5.
  - CS_n high at t=34, o_TX_Ready high at t=36.
- MISO pattern, slave drives 0x3C MSB-first, TX 0x00, H=3: o_RX_Byte=0x3C at t=48. MOSI stays 0 throughout.
- Burst of 3 bytes (0x11, 0x22, 0x33), i_TX_DV held high, H=2:
  - CS_n stays low for the whole burst.
  - o_RX_DV pulses 33 cycles apart (32 plus 1 WAIT_BYTE cycle).
  - CS_n rises 2 cycles after the third pulse.
- Burst stall: Count=2, second i_TX_DV delayed 20 cycles. CS_n stays low, SCLK stays 0, and o_TX_Ready=1 throughout the gap. The second byte transfers normally.
- Count=0 with i_TX_DV during XFER: exactly one byte is transferred. The spurious DV is ignored and no extra o_RX_DV is produced.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI mode-0 master controller.
package spi_pkg;

   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;
   localparam int   DEFAULT_CLKS_PER_HALF_BIT = 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_XFER      = 3'd1,
      ST_WAIT_BYTE = 3'd2,
      ST_CS_HOLD   = 3'd3,
      ST_CS_IDLE   = 3'd4
   } spi_state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-bit timer and registered SCLK; counter and phase return to idle whenever disabled.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int CLKS_PER_HALF_BIT = DEFAULT_CLKS_PER_HALF_BIT
)(
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Enable,
   output logic o_Rise_Strobe,
   output logic o_Fall_Strobe,
   output logic o_SPI_Clk
);

   localparam int               CNT_W    = $clog2(CLKS_PER_HALF_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_HALF_BIT - 1);

   logic [CNT_W-1:0] r_Half_Cnt;
   logic             r_SPI_Clk;
   logic             w_Half_Done;

   // Strobes are asserted in the cycle before the edge that toggles SCLK.
   assign w_Half_Done   = i_Enable && (r_Half_Cnt == CNT_LAST);
   assign o_Rise_Strobe = w_Half_Done && (r_SPI_Clk == SPI_CPOL);
   assign o_Fall_Strobe = w_Half_Done && (r_SPI_Clk != SPI_CPOL);
   assign o_SPI_Clk     = r_SPI_Clk;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_Half_Cnt <= '0;
         r_SPI_Clk  <= SPI_CPOL;
      end else if (!i_Enable) begin
         r_Half_Cnt <= '0;
         r_SPI_Clk  <= SPI_CPOL;
      end else if (w_Half_Done) begin
         r_Half_Cnt <= '0;
         r_SPI_Clk  <= ~r_SPI_Clk;
      end else begin
         r_Half_Cnt <= r_Half_Cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: byte handshake on the user side, CS/SCLK/MOSI sequencing and burst control.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int CLKS_PER_HALF_BIT = DEFAULT_CLKS_PER_HALF_BIT,
   parameter int CS_IDLE_CLKS      = 2
)(
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic [7:0] i_TX_Count,
   input  logic [7:0] i_TX_Byte,
   input  logic       i_TX_DV,
   output logic       o_TX_Ready,
   output logic [7:0] o_RX_Byte,
   output logic       o_RX_DV,
   output logic       o_Busy,
   output logic       o_SPI_Clk,
   input  logic       i_SPI_MISO,
   output logic       o_SPI_MOSI,
   output logic       o_SPI_CS_n
);

   localparam int WAIT_MAX = (CLKS_PER_HALF_BIT > CS_IDLE_CLKS) ? CLKS_PER_HALF_BIT : CS_IDLE_CLKS;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] HOLD_LAST = WAIT_W'(CLKS_PER_HALF_BIT - 1);
   localparam logic [WAIT_W-1:0] IDLE_LAST = WAIT_W'(CS_IDLE_CLKS - 1);

   spi_state_t        r_State,    w_State_Next;
   logic [7:0]        r_TX_Shift, w_TX_Shift_Next;
   logic [7:0]        r_RX_Shift, w_RX_Shift_Next;
   logic [7:0]        r_RX_Byte,  w_RX_Byte_Next;
   logic [7:0]        r_Remain,   w_Remain_Next;
   logic [2:0]        r_Bit_Cnt,  w_Bit_Cnt_Next;
   logic [WAIT_W-1:0] r_Wait_Cnt, w_Wait_Cnt_Next;
   logic              r_RX_DV,    w_RX_DV_Next;
   logic              r_TX_Ready, w_TX_Ready_Next;
   logic              r_Busy,     w_Busy_Next;
   logic              r_MOSI,     w_MOSI_Next;
   logic              r_CS_n,     w_CS_n_Next;
   logic              w_Rise, w_Fall, w_Sample, w_Shift, w_Accept, w_Clk_En;

   assign w_Clk_En = (r_State == ST_XFER);

   spi_clk_gen #(
      .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
   ) u_clk_gen (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_Enable     (w_Clk_En),
      .o_Rise_Strobe(w_Rise),
      .o_Fall_Strobe(w_Fall),
      .o_SPI_Clk    (o_SPI_Clk)
   );

   // Mode 0 samples on the leading edge and shifts on the trailing edge.
   assign w_Sample = SPI_CPHA ? w_Fall : w_Rise;
   assign w_Shift  = SPI_CPHA ? w_Rise : w_Fall;
   assign w_Accept = i_TX_DV && r_TX_Ready;

   always_comb begin
      w_State_Next    = r_State;
      w_TX_Shift_Next = r_TX_Shift;
      w_RX_Shift_Next = r_RX_Shift;
      w_RX_Byte_Next  = r_RX_Byte;
      w_Remain_Next   = r_Remain;
      w_Bit_Cnt_Next  = r_Bit_Cnt;
      w_Wait_Cnt_Next = r_Wait_Cnt;
      w_RX_DV_Next    = 1'b0;
      w_MOSI_Next     = r_MOSI;
      w_CS_n_Next     = r_CS_n;
      case (r_State)
         ST_IDLE: begin
            if (w_Accept) begin
               w_TX_Shift_Next = i_TX_Byte;
               w_MOSI_Next     = i_TX_Byte[7];
               w_Remain_Next   = (i_TX_Count == 8'd0) ? 8'd1 : i_TX_Count;
               w_Bit_Cnt_Next  = 3'd0;
               w_CS_n_Next     = 1'b0;
               w_State_Next    = ST_XFER;
            end
         end
         ST_XFER: begin
            if (w_Sample)
               w_RX_Shift_Next = {r_RX_Shift[6:0], i_SPI_MISO};
            if (w_Shift) begin
               w_Bit_Cnt_Next = r_Bit_Cnt + 3'd1;
               if (r_Bit_Cnt == 3'd7) begin
                  w_RX_Byte_Next = r_RX_Shift;
                  w_RX_DV_Next   = 1'b1;
                  w_Remain_Next  = r_Remain - 8'd1;
                  w_State_Next   = (r_Remain > 8'd1) ? ST_WAIT_BYTE : ST_CS_HOLD;
               end else begin
                  w_TX_Shift_Next = {r_TX_Shift[6:0], 1'b0};
                  w_MOSI_Next     = r_TX_Shift[6];
               end
            end
         end
         ST_WAIT_BYTE: begin
            if (w_Accept) begin
               w_TX_Shift_Next = i_TX_Byte;
               w_MOSI_Next     = i_TX_Byte[7];
               w_State_Next    = ST_XFER;
            end
         end
         ST_CS_HOLD: begin
            if (r_Wait_Cnt == HOLD_LAST) begin
               w_Wait_Cnt_Next = '0;
               w_CS_n_Next     = 1'b1;
               w_MOSI_Next     = 1'b0;
               w_State_Next    = ST_CS_IDLE;
            end else begin
               w_Wait_Cnt_Next = r_Wait_Cnt + 1'b1;
            end
         end
         ST_CS_IDLE: begin
            if (r_Wait_Cnt == IDLE_LAST) begin
               w_Wait_Cnt_Next = '0;
               w_State_Next    = ST_IDLE;
            end else begin
               w_Wait_Cnt_Next = r_Wait_Cnt + 1'b1;
            end
         end
         default: w_State_Next = ST_IDLE;
      endcase
      // Handshake flags are registered and follow the state being entered.
      w_TX_Ready_Next = (w_State_Next == ST_IDLE) || (w_State_Next == ST_WAIT_BYTE);
      w_Busy_Next     = (w_State_Next != ST_IDLE);
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_State    <= ST_IDLE;
         r_TX_Shift <= '0;
         r_RX_Shift <= '0;
         r_RX_Byte  <= '0;
         r_Remain   <= '0;
         r_Bit_Cnt  <= '0;
         r_Wait_Cnt <= '0;
         r_RX_DV    <= 1'b0;
         r_TX_Ready <= 1'b0;
         r_Busy     <= 1'b0;
         r_MOSI     <= 1'b0;
         r_CS_n     <= 1'b1;
      end else begin
         r_State    <= w_State_Next;
         r_TX_Shift <= w_TX_Shift_Next;
         r_RX_Shift <= w_RX_Shift_Next;
         r_RX_Byte  <= w_RX_Byte_Next;
         r_Remain   <= w_Remain_Next;
         r_Bit_Cnt  <= w_Bit_Cnt_Next;
         r_Wait_Cnt <= w_Wait_Cnt_Next;
         r_RX_DV    <= w_RX_DV_Next;
         r_TX_Ready <= w_TX_Ready_Next;
         r_Busy     <= w_Busy_Next;
         r_MOSI     <= w_MOSI_Next;
         r_CS_n     <= w_CS_n_Next;
      end
   end

   assign o_TX_Ready = r_TX_Ready;
   assign o_RX_Byte  = r_RX_Byte;
   assign o_RX_DV    = r_RX_DV;
   assign o_Busy     = r_Busy;
   assign o_SPI_MOSI = r_MOSI;
   assign o_SPI_CS_n = r_CS_n;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: a table of single-byte transactions plus burst/reset sequences.
module tb_spi_master_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0] tx_count = 8'd1;
   logic [7:0] tx_byte  = 8'd0;
   logic       a_dv = 1'b0, b_dv = 1'b0;
   logic       a_rdy, a_rxdv, a_busy, a_sclk, a_miso, a_mosi, a_csn;
   logic       b_rdy, b_rxdv, b_busy, b_sclk, b_miso, b_mosi, b_csn;
   logic [7:0] a_rx, b_rx;

   spi_master_ctrl #(.CLKS_PER_HALF_BIT(2), .CS_IDLE_CLKS(2)) dut_a (
      .i_Clk(clk), .i_Rst(rst), .i_TX_Count(tx_count), .i_TX_Byte(tx_byte), .i_TX_DV(a_dv),
      .o_TX_Ready(a_rdy), .o_RX_Byte(a_rx), .o_RX_DV(a_rxdv), .o_Busy(a_busy),
      .o_SPI_Clk(a_sclk), .i_SPI_MISO(a_miso), .o_SPI_MOSI(a_mosi), .o_SPI_CS_n(a_csn));

   spi_master_ctrl #(.CLKS_PER_HALF_BIT(3), .CS_IDLE_CLKS(2)) dut_b (
      .i_Clk(clk), .i_Rst(rst), .i_TX_Count(tx_count), .i_TX_Byte(tx_byte), .i_TX_DV(b_dv),
      .o_TX_Ready(b_rdy), .o_RX_Byte(b_rx), .o_RX_DV(b_rxdv), .o_Busy(b_busy),
      .o_SPI_Clk(b_sclk), .i_SPI_MISO(b_miso), .o_SPI_MOSI(b_mosi), .o_SPI_CS_n(b_csn));

   // Monitor mux: sel picks which instance the table entry exercises.
   logic       sel = 1'b0;
   logic       m_rdy, m_rxdv, m_busy, m_sclk, m_mosi, m_csn;
   logic [7:0] m_rx;
   assign m_rdy  = sel ? b_rdy  : a_rdy;
   assign m_rxdv = sel ? b_rxdv : a_rxdv;
   assign m_busy = sel ? b_busy : a_busy;
   assign m_sclk = sel ? b_sclk : a_sclk;
   assign m_mosi = sel ? b_mosi : a_mosi;
   assign m_csn  = sel ? b_csn  : a_csn;
   assign m_rx   = sel ? b_rx   : a_rx;

   // Mode-0 slave model: presents slave_byte MSB first, advancing after each SCLK rise.
   logic       loop_en = 1'b0;
   logic [7:0] slave_byte = 8'd0;
   logic [7:0] mosi_cap = 8'd0;
   int         rises = 0;
   int         rise_base = 0;
   logic [2:0] s_idx;
   logic [2:0] s_sel;
   logic       slave_bit;
   assign s_idx     = 3'(rises - rise_base);
   assign s_sel     = 3'd7 - s_idx;
   assign slave_bit = slave_byte[s_sel];
   assign a_miso    = loop_en ? a_mosi : slave_bit;
   assign b_miso    = slave_bit;

   always @(posedge m_sclk) begin
      rises    <= rises + 1;
      mosi_cap <= {mosi_cap[6:0], m_mosi};
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_ready(input string name);
      int w;
      w = 0;
      while (!m_rdy && w < 100) begin
         step();
         w++;
      end
      chk(name, int'(m_rdy), 1);
   endtask

   typedef struct {
      logic       sel;
      logic [7:0] tx;
      logic [7:0] cnt;
      logic       loop;
      logic [7:0] slave;
      logic [7:0] exp_rx;
      int         exp_rise;
      int         exp_dv;
      int         exp_cs;
      int         exp_rdy;
   } vec_t;

   vec_t vecs[6];

   task automatic run_vec(input vec_t v, input int idx);
      int         t_dv, n_dv, t_cs, t_rdy, t_rise;
      logic [7:0] rxb;
      sel        = v.sel;
      loop_en    = v.loop;
      slave_byte = v.slave;
      tx_byte    = v.tx;
      tx_count   = v.cnt;
      wait_ready("vec_ready_before");
      rise_base = rises;
      if (v.sel) b_dv = 1'b1; else a_dv = 1'b1;
      step();
      a_dv = 1'b0;
      b_dv = 1'b0;
      chk("vec_cs_low_t0", int'(m_csn), 0);
      chk("vec_busy_t0", int'(m_busy), 1);
      t_dv = -1; n_dv = 0; t_cs = -1; t_rdy = -1; t_rise = -1; rxb = 8'd0;
      for (int t = 1; t <= 70; t++) begin
         step();
         if (m_rxdv) begin
            n_dv++;
            if (t_dv < 0) begin
               t_dv = t;
               rxb  = m_rx;
            end
         end
         if (m_sclk && t_rise < 0) t_rise = t;
         if (m_csn && t_cs < 0) t_cs = t;
         if (m_rdy && t_rdy < 0) t_rdy = t;
      end
      chk("vec_first_rise_t", t_rise, v.exp_rise);
      chk("vec_rx_dv_t", t_dv, v.exp_dv);
      chk("vec_rx_dv_count", n_dv, 1);
      chk("vec_rx_byte", int'(rxb), int'(v.exp_rx));
      chk("vec_mosi_byte", int'(mosi_cap), int'(v.tx));
      chk("vec_sclk_rises", rises - rise_base, 8);
      chk("vec_cs_rise_t", t_cs, v.exp_cs);
      chk("vec_ready_t", t_rdy, v.exp_rdy);
      chk("vec_busy_end", int'(m_busy), 0);
      $display("vec %0d: H=%0d tx=%h rx=%h dv_t=%0d cs_t=%0d rdy_t=%0d",
               idx, v.sel ? 3 : 2, v.tx, rxb, t_dv, t_cs, t_rdy);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] burst[3];
      int         k, n_dv, last_dv, cs_t, csn_err, viol, t0;
      logic       prev_rdy;

      vecs[0] = '{1'b0, 8'hA5, 8'd1, 1'b1, 8'h00, 8'hA5, 2, 32, 34, 36};
      vecs[1] = '{1'b0, 8'h00, 8'd1, 1'b0, 8'hC3, 8'hC3, 2, 32, 34, 36};
      vecs[2] = '{1'b0, 8'hFF, 8'd0, 1'b0, 8'h00, 8'h00, 2, 32, 34, 36};
      vecs[3] = '{1'b0, 8'h5A, 8'd1, 1'b0, 8'h81, 8'h81, 2, 32, 34, 36};
      vecs[4] = '{1'b1, 8'h00, 8'd1, 1'b0, 8'h3C, 8'h3C, 3, 48, 51, 53};
      vecs[5] = '{1'b1, 8'h96, 8'd1, 1'b0, 8'h69, 8'h69, 3, 48, 51, 53};
      burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;

      // Reset state, then first cycle after release.
      repeat (3) step();
      chk("rst_cs_n", int'(a_csn), 1);
      chk("rst_sclk", int'(a_sclk), 0);
      chk("rst_mosi", int'(a_mosi), 0);
      chk("rst_ready", int'(a_rdy), 0);
      chk("rst_busy", int'(a_busy), 0);
      chk("rst_rx_dv", int'(a_rxdv), 0);
      chk("rst_rx_byte", int'(a_rx), 0);
      chk("rst_b_cs_n", int'(b_csn), 1);
      rst = 1'b0;
      step();
      chk("post_rst_ready_a", int'(a_rdy), 1);
      chk("post_rst_ready_b", int'(b_rdy), 1);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Reset asserted mid-transfer at t=5 abandons the byte.
      sel = 1'b0; loop_en = 1'b1; tx_byte = 8'hFF; tx_count = 8'd1;
      wait_ready("midrst_ready_before");
      a_dv = 1'b1;
      step();
      a_dv = 1'b0;
      repeat (5) step();
      chk("midrst_pre_cs_n", int'(a_csn), 0);
      chk("midrst_pre_mosi", int'(a_mosi), 1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_cs_n", int'(a_csn), 1);
      chk("midrst_sclk", int'(a_sclk), 0);
      chk("midrst_mosi", int'(a_mosi), 0);
      chk("midrst_rx_dv", int'(a_rxdv), 0);
      chk("midrst_busy", int'(a_busy), 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("midrst_ready_after", int'(a_rdy), 1);
      n_dv = 0;
      for (int t = 0; t < 40; t++) begin
         step();
         if (a_rxdv) n_dv++;
      end
      chk("midrst_no_rx_dv", n_dv, 0);
      $display("seq reset-mid-xfer: rx_dv after abort=%0d", n_dv);

      // Three-byte burst with i_TX_DV held high.
      loop_en = 1'b1; tx_count = 8'd3; tx_byte = burst[0];
      wait_ready("burst_ready_before");
      a_dv = 1'b1;
      k = 0; n_dv = 0; last_dv = -1; cs_t = -1; csn_err = 0;
      prev_rdy = a_rdy;
      for (int t = 0; t <= 110; t++) begin
         step();
         if (prev_rdy && a_dv) begin
            k++;
            if (k < 3) tx_byte = burst[k];
            else a_dv = 1'b0;
         end
         prev_rdy = a_rdy;
         if (a_rxdv) begin
            if (n_dv < 3) chk("burst_rx_byte", int'(a_rx), int'(burst[n_dv]));
            if (n_dv > 0) chk("burst_dv_gap", t - last_dv, 33);
            last_dv = t;
            n_dv++;
         end
         if (n_dv < 3 && a_csn) csn_err++;
         if (n_dv == 3 && a_csn && cs_t < 0) cs_t = t;
      end
      a_dv = 1'b0;
      chk("burst_dv_count", n_dv, 3);
      chk("burst_cs_low", csn_err, 0);
      chk("burst_cs_rise_after_last", cs_t - last_dv, 2);
      $display("seq burst: pulses=%0d last_dv_t=%0d cs_t=%0d", n_dv, last_dv, cs_t);

      // Burst of two with a 20-cycle stall between bytes.
      tx_count = 8'd2; tx_byte = 8'h5C;
      wait_ready("stall_ready_before");
      a_dv = 1'b1;
      step();
      a_dv = 1'b0;
      t0 = -1;
      for (int t = 1; t <= 40 && t0 < 0; t++) begin
         step();
         if (a_rxdv) begin
            t0 = t;
            chk("stall_rx_byte1", int'(a_rx), 8'h5C);
         end
      end
      chk("stall_dv1_t", t0, 32);
      viol = 0;
      for (int t = 0; t < 20; t++) begin
         step();
         if (a_csn || a_sclk || !a_rdy) viol++;
      end
      chk("stall_gap_hold", viol, 0);
      tx_byte = 8'hE7;
      a_dv = 1'b1;
      step();
      a_dv = 1'b0;
      t0 = -1; viol = 0;
      for (int t = 1; t <= 40 && t0 < 0; t++) begin
         step();
         if (a_rxdv) begin
            t0 = t;
            chk("stall_rx_byte2", int'(a_rx), 8'hE7);
         end else if (a_csn) viol++;
      end
      chk("stall_dv2_t", t0, 32);
      chk("stall_cs_low_byte2", viol, 0);
      $display("seq stall: second byte dv_t=%0d", t0);

      // Count=0 with a spurious DV during the transfer: exactly one byte.
      tx_count = 8'd0; tx_byte = 8'h3C;
      wait_ready("cnt0_ready_before");
      a_dv = 1'b1;
      step();
      a_dv = 1'b0;
      n_dv = 0; cs_t = -1;
      for (int t = 1; t <= 60; t++) begin
         if (t >= 10 && t <= 14) begin
            tx_byte = 8'hAA; tx_count = 8'd5; a_dv = 1'b1;
         end else begin
            a_dv = 1'b0;
         end
         step();
         if (a_rxdv) begin
            n_dv++;
            chk("cnt0_rx_byte", int'(a_rx), 8'h3C);
         end
         if (a_csn && cs_t < 0) cs_t = t;
      end
      a_dv = 1'b0;
      chk("cnt0_dv_count", n_dv, 1);
      chk("cnt0_cs_rise_t", cs_t, 34);
      $display("seq count0: pulses=%0d cs_t=%0d", n_dv, cs_t);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
